label_table_mp: RTL
===================

Name: label_table_mp

Overview:
- Parametrised successor to the single-port label table.
- Holds per-label type, base and count, plus a per-entry valid bit.
- Provides two registered read ports, each with bounds checking and effective-address generation.
- A sequential flush engine invalidates every entry after reset or on request.
- Sits between the instruction decoder (label lookups for two pointer operands) and the memory access unit (address/fault).

Parameters:
LBIDWidth, 8, label index width; table depth = 2**LBIDWidth
TypeWidth, 6, label type field width
AddrWidth, 16, base/count/offset/address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  request invalidation of all entries
busy  out  1  flush in progress; table unusable
we  in  1  write strobe
wkill  in  1  with we: invalidate entry lbidw instead of writing it
wready  out  1  write accepted this cycle
lbidw  in  LBIDWidth  write index
typw  in  TypeWidth  write type
basew  in  AddrWidth  write base
countw  in  AddrWidth  write count
ren0/ren1  in  1  read request, port 0/1
lbid0/lbid1  in  LBIDWidth  read index
off0/off1  in  AddrWidth  element offset
rvalid0/rvalid1  out  1  result valid (registered ren)
hit0/hit1  out  1  entry valid
typ0/typ1  out  TypeWidth  entry type
base0/base1  out  AddrWidth  entry base
count0/count1  out  AddrWidth  entry count
addr0/addr1  out  AddrWidth  base+off, modulo 2**AddrWidth
fault0/fault1  out  1  !hit or off >= count

Behaviour:
- States: CLEAR, IDLE.
- rst_n low: state=CLEAR, clear index=0, busy=1, every read-port output 0, wready=0.
- CLEAR: each cycle clears valid[clear index] and increments the index. When the index reaches 2**LBIDWidth-1, that entry is cleared and the state moves to IDLE next cycle. The flush takes exactly 2**LBIDWidth cycles. flush is ignored in CLEAR.
- IDLE: flush=1 moves to CLEAR with clear index=0 next cycle.
- busy = (state==CLEAR).
- wready = (state==IDLE) && !flush. Combinational; no dependence on we.
- Write accepted when we && wready:
  - wkill=0: type/base/count written and valid set.
  - wkill=1: only valid cleared; data unchanged.
- Write with flush in the same cycle: flush wins, write dropped, wready=0.
- Reads: latency 1 cycle.
  - rvalidN at edge k+1 = renN at edge k.
  - With ren=0, rvalidN=0 and the other port outputs hold their previous values.
- Reads during CLEAR are accepted; they return whatever the valid bit holds at that edge, so cleared entries give hit=0, fault=1.
- Read and write to the same index in the same cycle: the read returns the pre-write contents (old data, old valid).
- Both ports may read the same index simultaneously; the ports are independent.
- Arithmetic:
  - addr = base + off, truncated to AddrWidth; no carry out.
  - fault is an unsigned compare. count=0 always faults.
  - addr is driven even when fault=1.
- Storage:
  - Valid bits are flops (needed for the clear engine and reset).
  - Type/base/count arrays are non-reset RAM-style storage with one write port and two read ports.
- rst_n asserted mid-flush or mid-operation: state restarts at CLEAR, index 0. Data arrays are not reset; valid bits are cleared by the flush walk, not by reset.

Decomposition:
- Shared package holds:
  - state encoding (CLEAR/IDLE);
  - default widths LBIDWidth/TypeWidth/AddrWidth;
  - the fault-condition helper definition.
- Sub-module label_read_port: registered read of one port plus the addr/fault computation. Instantiated twice.

Test Plan:
- Release rst_n: busy=1 for exactly 256 cycles (LBIDWidth=8), wready=0 throughout; then busy=0, wready=1. Reading lbid0=5 right after the flush gives hit0=0, fault0=1.
- Write lbidw=3, typ=0x05, base=0x1000, count=0x0010; next cycle read lbid0=3, off0=0x000F -> next cycle rvalid0=1, hit0=1, typ0=0x05, addr0=0x100F, fault0=0. Off0=0x0010 gives fault0=1, addr0=0x1010.
- Entry base=0xFFF0, count=0x0040, read with off=0x0020 -> addr=0x0010 (wrap), fault=0.
- Same cycle: write lbid 7 (count=4), port 0 and port 1 both read lbid 7. Both ports return hit=0 (old contents). A repeat read next cycle gives hit=1, count=4.
- In IDLE, assert flush together with we to lbid 2 -> wready=0, write dropped, busy=1 next cycle for 256 cycles, lbid 2 hit=0 afterwards. Then we+wkill on a valid entry -> hit=0, fault=1.
- Pulse rst_n low at flush cycle 100 -> busy stays 1; flush completes exactly 256 cycles after release; all read outputs are 0 during reset.

Source files
------------

// File: rtl/label_table_mp_pkg.sv
// label_table_mp_pkg
// Shared definitions for the dual-read-port label table: default field
// widths, the flush/idle state encoding and the bounds-fault helper used
// by each read port.
package label_table_mp_pkg;

    localparam int DefLBIDWidth = 8;
    localparam int DefTypeWidth = 6;
    localparam int DefAddrWidth = 16;

    // Widest address the fault helper can compare; callers size-cast into it.
    localparam int MaxAddrWidth = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // A lookup faults when the entry is invalid or the offset falls outside
    // [0, count). The compare is unsigned, so count==0 always faults.
    function automatic logic fault_check(input logic                    hit,
                                         input logic [MaxAddrWidth-1:0] off,
                                         input logic [MaxAddrWidth-1:0] count);
        return !hit || (off >= count);
    endfunction

endpackage

// File: rtl/label_table_mp_if.sv
// label_table_mp_if
// Bundles the label table's flush, write and two read-port signals.
//   master : decoder / memory-unit side (drives requests, sees results)
//   slave  : the table itself
interface label_table_mp_if
    import label_table_mp_pkg::*;
#(
    parameter int LBIDWidth = DefLBIDWidth,
    parameter int TypeWidth = DefTypeWidth,
    parameter int AddrWidth = DefAddrWidth
) ();

    logic                 flush;
    logic                 busy;

    logic                 we;
    logic                 wkill;
    logic                 wready;
    logic [LBIDWidth-1:0] lbidw;
    logic [TypeWidth-1:0] typw;
    logic [AddrWidth-1:0] basew;
    logic [AddrWidth-1:0] countw;

    logic                 ren0,    ren1;
    logic [LBIDWidth-1:0] lbid0,   lbid1;
    logic [AddrWidth-1:0] off0,    off1;
    logic                 rvalid0, rvalid1;
    logic                 hit0,    hit1;
    logic [TypeWidth-1:0] typ0,    typ1;
    logic [AddrWidth-1:0] base0,   base1;
    logic [AddrWidth-1:0] count0,  count1;
    logic [AddrWidth-1:0] addr0,   addr1;
    logic                 fault0,  fault1;

    modport master (
        output flush, we, wkill, lbidw, typw, basew, countw,
               ren0, lbid0, off0, ren1, lbid1, off1,
        input  busy, wready,
               rvalid0, hit0, typ0, base0, count0, addr0, fault0,
               rvalid1, hit1, typ1, base1, count1, addr1, fault1
    );

    modport slave (
        input  flush, we, wkill, lbidw, typw, basew, countw,
               ren0, lbid0, off0, ren1, lbid1, off1,
        output busy, wready,
               rvalid0, hit0, typ0, base0, count0, addr0, fault0,
               rvalid1, hit1, typ1, base1, count1, addr1, fault1
    );

endinterface

// File: rtl/label_table_mp_read_port.sv
// label_read_port
// One registered lookup port. The table presents the combinational entry
// contents selected by this port's index; on ren they are captured along
// with base+off and the bounds fault. Without ren only rvalid drops and the
// remaining outputs keep the last result.
// Ports:
//   clk, rst_n            clock, async active-low reset (all outputs to 0)
//   ren, off              request strobe and element offset
//   ent_valid/typ/base/count  entry contents at the requested index
//   rvalid, hit, typ, base, count, addr, fault  registered lookup result
module label_read_port
    import label_table_mp_pkg::*;
#(
    parameter int TypeWidth = DefTypeWidth,
    parameter int AddrWidth = DefAddrWidth
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ren,
    input  logic [AddrWidth-1:0] off,
    input  logic                 ent_valid,
    input  logic [TypeWidth-1:0] ent_typ,
    input  logic [AddrWidth-1:0] ent_base,
    input  logic [AddrWidth-1:0] ent_count,
    output logic                 rvalid,
    output logic                 hit,
    output logic [TypeWidth-1:0] typ,
    output logic [AddrWidth-1:0] base,
    output logic [AddrWidth-1:0] count,
    output logic [AddrWidth-1:0] addr,
    output logic                 fault
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            hit    <= 1'b0;
            typ    <= '0;
            base   <= '0;
            count  <= '0;
            addr   <= '0;
            fault  <= 1'b0;
        end else begin
            rvalid <= ren;
            if (ren) begin
                hit   <= ent_valid;
                typ   <= ent_typ;
                base  <= ent_base;
                count <= ent_count;
                // Wraps modulo 2**AddrWidth; produced even when faulting.
                addr  <= ent_base + off;
                fault <= fault_check(ent_valid,
                                     MaxAddrWidth'(off),
                                     MaxAddrWidth'(ent_count));
            end
        end
    end

endmodule

// File: rtl/label_table_mp.sv
// label_table_mp
// Label table with per-entry type/base/count and valid bit, one write port
// and two registered read ports with bounds checking. After reset, or on a
// flush request, a walk clears one valid bit per cycle; the table reports
// busy and refuses writes until the walk finishes.
// Ports:
//   clk    clock
//   rst_n  async active-low reset (restarts the clear walk)
//   bus    label_table_mp_if.slave: flush/busy, write port, read ports 0/1
module label_table_mp
    import label_table_mp_pkg::*;
#(
    parameter int LBIDWidth = DefLBIDWidth,
    parameter int TypeWidth = DefTypeWidth,
    parameter int AddrWidth = DefAddrWidth
) (
    input  logic              clk,
    input  logic              rst_n,
    label_table_mp_if.slave   bus
);

    localparam int Depth = 2 ** LBIDWidth;

    state_t               state;
    logic [LBIDWidth-1:0] clr_idx;
    logic                 wr_en;

    // Valid bits are flops so the walk can clear them; the data arrays are
    // plain RAM-style storage and never reset.
    logic                 valid    [Depth];
    logic [TypeWidth-1:0] typ_mem  [Depth];
    logic [AddrWidth-1:0] base_mem [Depth];
    logic [AddrWidth-1:0] cnt_mem  [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (&clr_idx) state <= IDLE;
                end
                IDLE: begin
                    if (bus.flush) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    assign bus.busy   = (state == CLEAR);
    // A flush in the same cycle as a write takes priority and drops it.
    assign bus.wready = (state == IDLE) && !bus.flush;
    assign wr_en      = bus.we && bus.wready;

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            valid[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid[bus.lbidw] <= !bus.wkill;
        end
    end

    // A kill only clears the valid bit; stale data stays readable.
    always_ff @(posedge clk) begin
        if (wr_en && !bus.wkill) begin
            typ_mem[bus.lbidw]  <= bus.typw;
            base_mem[bus.lbidw] <= bus.basew;
            cnt_mem[bus.lbidw]  <= bus.countw;
        end
    end

    // Array reads are taken before this edge's write lands, so a same-cycle
    // read of the written index sees the old entry.
    label_read_port #(.TypeWidth(TypeWidth), .AddrWidth(AddrWidth)) u_port0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ren       (bus.ren0),
        .off       (bus.off0),
        .ent_valid (valid[bus.lbid0]),
        .ent_typ   (typ_mem[bus.lbid0]),
        .ent_base  (base_mem[bus.lbid0]),
        .ent_count (cnt_mem[bus.lbid0]),
        .rvalid    (bus.rvalid0),
        .hit       (bus.hit0),
        .typ       (bus.typ0),
        .base      (bus.base0),
        .count     (bus.count0),
        .addr      (bus.addr0),
        .fault     (bus.fault0)
    );

    label_read_port #(.TypeWidth(TypeWidth), .AddrWidth(AddrWidth)) u_port1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ren       (bus.ren1),
        .off       (bus.off1),
        .ent_valid (valid[bus.lbid1]),
        .ent_typ   (typ_mem[bus.lbid1]),
        .ent_base  (base_mem[bus.lbid1]),
        .ent_count (cnt_mem[bus.lbid1]),
        .rvalid    (bus.rvalid1),
        .hit       (bus.hit1),
        .typ       (bus.typ1),
        .base      (bus.base1),
        .count     (bus.count1),
        .addr      (bus.addr1),
        .fault     (bus.fault1)
    );

endmodule
